// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports, one write port, optional bypass and hardwired-zero entry 0.
// Writes land one edge later; a sequential clear engine zeroes one entry per edge while Busy is high, and writes are dropped during that time.
module param_register_file #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic                 Clear,
    output logic                 Busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   ptr_q;
    logic                   busy_q;
    logic [WIDTH-1:0]       mem_q [DEPTH];

    logic                   mem_we_d;
    logic [ADDR_BITS-1:0]   mem_wa_d;
    logic [WIDTH-1:0]       mem_wd_d;
    logic                   wr_live;
    logic                   wr_zero_drop;

    assign Busy = busy_q;

    // A write is live only when the engine is idle; Busy is what the pipeline stalls on.
    assign wr_live      = RegWrite && !busy_q;
    assign wr_zero_drop = (ZERO_REG != 0) && (WriteRegister == '0);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Clear) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    ptr_q <= ptr_q + ADDR_BITS'(1);
                    if (ptr_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Single storage write port shared by the clear engine and the pipeline write.
    always_comb begin
        mem_we_d = 1'b0;
        mem_wa_d = WriteRegister;
        mem_wd_d = WriteData;
        if (Reset_n) begin
            if (state_q == ST_CLEAR) begin
                mem_we_d = 1'b1;
                mem_wa_d = ptr_q;
                mem_wd_d = '0;
            end else if (wr_live && !wr_zero_drop) begin
                mem_we_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we_d) begin
            mem_q[mem_wa_d] <= mem_wd_d;
        end
    end

    always_comb begin
        ReadData1 = mem_q[ReadRegister1];
        if (busy_q) begin
            ReadData1 = '0;
        end else if ((ZERO_REG != 0) && (ReadRegister1 == '0)) begin
            ReadData1 = '0;
        end else if ((BYPASS != 0) && wr_live && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = mem_q[ReadRegister2];
        if (busy_q) begin
            ReadData2 = '0;
        end else if ((ZERO_REG != 0) && (ReadRegister2 == '0)) begin
            ReadData2 = '0;
        end else if ((BYPASS != 0) && wr_live && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
        end
    end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised successor to the CPU's fixed 32x32 register file. It has configurable word width and depth, a hardwired-zero entry 0, two asynchronous read ports and one synchronous write port. It adds an optional same-cycle write-to-read bypass and a sequential clear engine that zeroes every entry one per cycle after reset or on request, signalling Busy to the pipeline. It sits in the CPU datapath between decode (read addresses) and writeback (write port).

## Interface
- WIDTH, 32: bits per register word.
- ADDR_BITS, 5: address width; DEPTH = 2^ADDR_BITS entries.
- ZERO_REG, 1: 1 means entry 0 always reads 0 and ignores writes; 0 means entry 0 is an ordinary register.
- BYPASS, 1: 1 means a read of the entry being written this cycle returns WriteData; 0 means it returns the stored value.

Ports:
- Clk  in  1  clock; all state updates on the positive edge.
- Reset_n  in  1  synchronous, active-low reset, sampled on the positive Clk edge.
- ReadRegister1  in  ADDR_BITS  read port 1 address.
- ReadRegister2  in  ADDR_BITS  read port 2 address.
- ReadData1  out  WIDTH  read port 1 data (combinational).
- ReadData2  out  WIDTH  read port 2 data (combinational).
- WriteRegister  in  ADDR_BITS  write address.
- WriteData  in  WIDTH  write data.
- RegWrite  in  1  write enable, active high.
- Clear  in  1  request to zero all entries; one-cycle pulse or level.
- Busy  out  1  registered; high while the clear engine runs.

## Operation
- State machine has two states:
  - IDLE: normal operation.
  - CLEAR: a pointer Ptr (ADDR_BITS wide) walks the entries.
- Reset: Reset_n low at an edge sets state CLEAR, Ptr=0 and Busy=1 (reset value of Busy is 1). Entry contents are not reset directly; the engine zeroes them. Holding Reset_n low holds Ptr at 0.
- IDLE to CLEAR: Clear high at an edge sets Ptr=0 and Busy=1.
- CLEAR: each edge writes 0 to entry Ptr and increments Ptr.
  - The edge with Ptr==DEPTH-1 writes the last entry, then sets state IDLE and Busy=0.
  - Ptr does not wrap into a second pass.
- Clear while in CLEAR is ignored; the sequence does not restart.
- Reset_n low mid-clear restarts the sequence at Ptr=0.
- Write:
  - An edge with RegWrite=1 and Busy=0 stores WriteData into WriteRegister.
  - Exception: with ZERO_REG=1, writes to entry 0 are dropped.
  - RegWrite while Busy=1 is dropped silently. The pipeline must stall on Busy.
- Clear and RegWrite both high at the same edge in IDLE: the write is performed and the clear then starts. The written entry is zeroed later in the sequence.
- Read (per port N, combinational), in priority order:
  1. Busy=1 returns 0.
  2. ZERO_REG=1 and address 0 returns 0.
  3. BYPASS=1 and RegWrite=1 and WriteRegister==ReadRegisterN (non-dropped write) returns WriteData.
  4. Otherwise returns the stored entry.
- Both ports may read the same address simultaneously with identical results.
- No width conversion; all data paths are WIDTH bits.

## Timing
- Write latency: 1 edge. Data is visible on reads after the edge, or in the same cycle when BYPASS=1.
- Read latency: 0 (combinational from address, Busy and the bypass inputs).
- Busy rises on the edge that accepts Reset_n low or Clear, and stays high for exactly DEPTH edges after entering CLEAR.
  - Example: DEPTH=32 gives Busy high for 32 cycles after reset deasserts.
- First accepted write: the edge after Busy falls.
- Busy is registered; there is no combinational path from Clear or Reset_n to Busy.

## Test plan
- Reset (DEPTH=32): hold Reset_n low for 2 edges, then release. Required:
  - Busy=1 for exactly 32 edges, with ReadData1/2 = 0 throughout.
  - Busy then falls and every entry reads 0.
- Basic write (WIDTH=32): write 42 then 15 to reg 2 (RegWrite=1) and read reg 2 on both ports. Required:
  - Reads return 42, then 15.
  - With RegWrite=0 and WriteData=17, reg 2 still reads 15.
- Decode and zero: write 19 to reg 3 and check reg 2 is unchanged at 15; write 15 to reg 0. Required:
  - ZERO_REG=1: reg 0 reads 0 on both ports.
  - ZERO_REG=0: reg 0 reads 15.
- Bypass: reg 5 holds 9; in the same cycle present a write of 7 to reg 5 and read reg 5. Required before the edge:
  - BYPASS=1: reads 7.
  - BYPASS=0: reads 9.
  - After the edge both modes read 7.
- Clear mid-use: fill regs 1–31 with distinct values, pulse Clear together with a write of 5 to reg 4, then attempt a write of 8 to reg 6 while Busy. Required:
  - Busy high for 32 edges.
  - The write to reg 6 is dropped.
  - Afterwards all entries read 0, including reg 4.
- Reset mid-clear: pulse Clear, wait 10 edges, assert Reset_n low for 1 edge. Required: Busy stays high for a further full 32 edges counted from the release, then falls.
